dac_spi_slave: RTL and testbench

- SPI responder for the DAC serial port: the receiving end of the 24-bit {address_byte, data[15:0]} frames sent by the DAC SPI master.
- Oversamples sclk, latch and din in the single clk domain, deserialises MSB-first frames and commits a frame on the latch rising edge.
- Holds the DAC data and control registers and drives read-back data on sdo.
- Used as the on-chip DAC model for loopback test and as a protocol checker on the DAC pins.

---
 rtl/dac_spi_pkg.sv | 25 ++
 rtl/spi_in_sync.sv | 32 +++
 rtl/dac_spi_slave.sv | 129 ++++++++++++
 tb/tb_dac_spi_slave.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dac_spi_pkg.sv
// Shared constants, FSM state type and read-back selection for the DAC SPI responder.
package dac_spi_pkg;

    localparam int DEF_FRAME_BITS = 24;

    localparam logic [7:0] ADDR_NOP  = 8'h00;
    localparam logic [7:0] ADDR_DAC  = 8'h01;
    localparam logic [7:0] ADDR_CTRL = 8'h02;

    localparam logic [1:0] RB_DAC  = 2'b01;
    localparam logic [1:0] RB_CTRL = 2'b10;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    function automatic logic [15:0] rb_select(input logic [1:0]  sel,
                                              input logic [15:0] dac,
                                              input logic [15:0] ctrl);
        case (sel)
            RB_DAC:  return dac;
            RB_CTRL: return ctrl;
            default: return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-flop synchroniser for one asynchronous SPI pin, with edge pulses on the synchronised copy.
module spi_in_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: non-blocking assignments so each stage takes the previous stage's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/dac_spi_slave.sv
// DAC SPI responder: oversamples the serial pins, decodes 24-bit frames on latch rise,
// holds the DAC/control registers and shifts read-back data out on sdo.
module dac_spi_slave
    import dac_spi_pkg::*;
#(
    parameter int          FRAME_BITS  = DEF_FRAME_BITS,
    parameter logic [15:0] CLEAR_CODE  = 16'h8000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk,
    input  logic        latch,
    input  logic        din,
    input  logic        clr,
    output logic        sdo,
    output logic [15:0] dac_code,
    output logic [15:0] ctrl_reg,
    output logic        dac_update,
    output logic        frame_err
);

    state_t      state, state_nxt;
    logic [23:0] rx_sr;
    logic [23:0] tx_sr;
    logic [4:0]  bit_cnt;

    logic sclk_rise, sclk_fall, latch_rise, latch_fall, din_s;
    logic sclk_lvl, latch_lvl, din_rise, din_fall;
    logic unused_sync;

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .async_in(sclk),
        .sync_out(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
    );

    // Latch idles high, so its synchroniser resets high to avoid a phantom edge.
    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_latch_sync (
        .clk(clk), .rst_n(rst_n), .async_in(latch),
        .sync_out(latch_lvl), .rise(latch_rise), .fall(latch_fall)
    );

    spi_in_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din_sync (
        .clk(clk), .rst_n(rst_n), .async_in(din),
        .sync_out(din_s), .rise(din_rise), .fall(din_fall)
    );

    assign unused_sync = ^{sclk_lvl, latch_lvl, din_rise, din_fall};

    // Decode happens on the SHIFT->COMMIT transition so registers land one clk after
    // the synchronised latch rise; COMMIT itself is the one-clk dwell afterwards.
    logic        commit, frame_ok, wr_dac, wr_ctrl, bad_frame;
    logic [7:0]  addr;
    logic [15:0] data;

    assign commit   = (state == SHIFT) && latch_rise;
    assign frame_ok = (bit_cnt == 5'(FRAME_BITS));
    assign addr     = rx_sr[23:16];
    assign data     = rx_sr[15:0];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (latch_fall) state_nxt = SHIFT;
            SHIFT:   if (latch_rise) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wr_dac    = 1'b0;
        wr_ctrl   = 1'b0;
        bad_frame = 1'b0;
        if (commit) begin
            if (!frame_ok) begin
                bad_frame = 1'b1;
            end else begin
                case (addr)
                    ADDR_NOP:  ;
                    ADDR_DAC:  wr_dac    = 1'b1;
                    ADDR_CTRL: wr_ctrl   = 1'b1;
                    default:   bad_frame = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rx_sr   <= '0;
            tx_sr   <= '0;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && latch_fall) begin
                bit_cnt <= '0;
                tx_sr   <= {8'h00, rb_select(ctrl_reg[1:0], dac_code, ctrl_reg)};
            end else if (state == SHIFT) begin
                if (sclk_rise) begin
                    rx_sr <= {rx_sr[22:0], din_s};
                    if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
                end
                if (sclk_fall) tx_sr <= {tx_sr[22:0], 1'b0};
            end
        end
    end

    // clr has priority over a same-clk write to the DAC register and suppresses its pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_code   <= CLEAR_CODE;
            ctrl_reg   <= '0;
            dac_update <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (clr)         dac_code <= CLEAR_CODE;
            else if (wr_dac) dac_code <= data;
            if (wr_ctrl) ctrl_reg <= data;
            dac_update <= wr_dac & ~clr;
            frame_err  <= bad_frame;
        end
    end

    assign sdo = (state != IDLE) & tx_sr[23];

endmodule

// File: tb/tb_dac_spi_slave.sv
// Directed testbench for dac_spi_slave: bit-banged SPI frames with hand-computed expectations.
module tb_dac_spi_slave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sclk = 1'b0;
    logic        latch = 1'b1;
    logic        din = 1'b0;
    logic        clr = 1'b0;
    logic        sdo;
    logic [15:0] dac_code;
    logic [15:0] ctrl_reg;
    logic        dac_update;
    logic        frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    int          upd_cnt, err_cnt, upd_at;
    logic [31:0] rb;

    dac_spi_slave dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .latch(latch), .din(din), .clr(clr),
        .sdo(sdo), .dac_code(dac_code), .ctrl_reg(ctrl_reg),
        .dac_update(dac_update), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Shift n bits MSB first; sdo is sampled just before each sclk rise.
    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            din = v[i];
            cyc(4);
            rb = {rb[30:0], sdo};
            sclk = 1'b1;
            cyc(4);
            sclk = 1'b0;
        end
    endtask

    // Full frame; clr_k selects which post-latch clk gets clr (-1 = none).
    task automatic frame(input logic [31:0] v, input int n, input int clr_k);
        upd_cnt = 0;
        err_cnt = 0;
        upd_at  = -1;
        rb      = '0;
        latch   = 1'b0;
        cyc(4);
        shift_bits(v, n);
        cyc(4);
        latch = 1'b1;
        for (int k = 0; k < 10; k++) begin
            clr = (k == clr_k);
            cyc(1);
            if (dac_update) begin
                upd_cnt++;
                if (upd_at < 0) upd_at = k;
            end
            if (frame_err) err_cnt++;
        end
        clr = 1'b0;
    endtask

    initial begin
        cyc(3);
        check("rst_dac", 32'(dac_code), 32'h8000);
        check("rst_ctrl", 32'(ctrl_reg), 32'h0);
        check("rst_sdo", 32'(sdo), 32'h0);
        check("rst_upd", 32'(dac_update), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        cyc(3);

        frame(32'h0001_ABCD, 24, -1);
        check("wr_dac_code", 32'(dac_code), 32'hABCD);
        check("wr_dac_upd_cnt", upd_cnt, 1);
        check("wr_dac_latency", upd_at, 2);
        check("wr_dac_err", err_cnt, 0);
        check("wr_dac_rb", rb & 32'hFF_FFFF, 32'h0);

        frame(32'h0000_ABCD, 23, -1);
        check("short_err", err_cnt, 1);
        check("short_upd", upd_cnt, 0);
        check("short_dac", 32'(dac_code), 32'hABCD);

        frame(32'h0002_0001, 24, -1);
        check("wr_ctrl", 32'(ctrl_reg), 32'h0001);
        check("wr_ctrl_err", err_cnt, 0);
        frame(32'h0000_0000, 24, -1);
        check("nop_rb", rb & 32'hFF_FFFF, 32'h00_ABCD);
        check("nop_err", err_cnt, 0);
        check("nop_upd", upd_cnt, 0);
        check("nop_ctrl", 32'(ctrl_reg), 32'h0001);

        frame(32'h0001_1234, 24, 2);
        check("clr_dac", 32'(dac_code), 32'h8000);
        check("clr_upd", upd_cnt, 0);
        check("clr_err", err_cnt, 0);
        check("clr_rb", rb & 32'hFF_FFFF, 32'h00_ABCD);

        frame(32'h007F_5555, 24, -1);
        check("badaddr_err", err_cnt, 1);
        check("badaddr_dac", 32'(dac_code), 32'h8000);
        check("badaddr_ctrl", 32'(ctrl_reg), 32'h0001);

        frame(32'h0101_5A5A, 26, -1);
        check("long_err", err_cnt, 1);
        check("long_upd", upd_cnt, 0);
        check("long_dac", 32'(dac_code), 32'h8000);

        // Partial frame interrupted by reset.
        rb    = '0;
        latch = 1'b0;
        cyc(4);
        shift_bits(32'h0001_0777, 12);
        rst_n = 1'b0;
        latch = 1'b1;
        cyc(2);
        check("midrst_dac", 32'(dac_code), 32'h8000);
        check("midrst_ctrl", 32'(ctrl_reg), 32'h0);
        check("midrst_state", 32'(dut.state), 32'h0);
        check("midrst_sdo", 32'(sdo), 32'h0);
        rst_n = 1'b1;
        err_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (frame_err) err_cnt++;
        end
        check("midrst_noerr", err_cnt, 0);

        frame(32'h0001_0042, 24, -1);
        check("post_rst_dac", 32'(dac_code), 32'h0042);
        check("post_rst_upd", upd_cnt, 1);
        check("post_rst_err", err_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
